// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result handshake bundle for alu_pipe
// Request side: in_valid, in_ready, funct3, funct7, a, b, in_tag.
// Result side: out_valid, out_ready, result, out_tag, illegal (+ flag_z/n/c/v when ALU_FLAGS_EN is defined).
// master drives requests and consumes results; slave is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic in_valid;
  logic in_ready;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic illegal;
`ifdef ALU_FLAGS_EN
  logic flag_z;
  logic flag_n;
  logic flag_c;
  logic flag_v;
`endif
  modport master (
    output in_valid, funct3, funct7, a, b, in_tag, out_ready,
    input in_ready, out_valid, result, out_tag, illegal
`ifdef ALU_FLAGS_EN
    , input flag_z, flag_n, flag_c, flag_v
`endif
  );
  modport slave (
    input in_valid, funct3, funct7, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, illegal
`ifdef ALU_FLAGS_EN
    , output flag_z, flag_n, flag_c, flag_v
`endif
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined RISC-V R-type ALU with valid/ready handshake on both sides
// Ports: clk (rising edge), rst (synchronous, active-high), bus (alu_pipe_if.slave):
//   request  in_valid/in_ready, funct3, funct7, a, b, in_tag
//   result   out_valid/out_ready, result, out_tag, illegal
// Optional: define ALU_FLAGS_EN to add flag_z/flag_n/flag_c/flag_v, registered with result.
// Stage 1 holds the decoded op and operands, stage 2 holds the result; capacity is two requests.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  alu_pipe_if.slave bus
);
  localparam int SH = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  logic in_fire;
  logic f7_zero;
  logic f7_alt;
  logic [3:0] dec_op;
  logic dec_illegal;
  logic [3:0] s1_op;
  logic s1_illegal;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic [SH-1:0] shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sra;
  logic lt_s;
  logic lt_u;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_q;
  logic illegal_q;
  // A slot opens in stage 2 when it is empty or draining; stage 1 can then always advance.
  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;
  assign in_fire = bus.in_valid && s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.result = result_q;
  assign bus.out_tag = tag_q;
  assign bus.illegal = illegal_q;
  assign f7_zero = bus.funct7 == 7'b0000000;
  assign f7_alt = bus.funct7 == 7'b0100000;
  // Only ADD/SUB (000) and SRL/SRA (101) accept the alternate funct7 encoding.
  assign dec_illegal = !(f7_zero || (f7_alt && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101)));
  assign dec_op = bus.funct3 == 3'b000 ? (f7_alt ? OP_SUB : OP_ADD) :
                  bus.funct3 == 3'b001 ? OP_SLL :
                  bus.funct3 == 3'b010 ? OP_SLT :
                  bus.funct3 == 3'b011 ? OP_SLTU :
                  bus.funct3 == 3'b100 ? OP_XOR :
                  bus.funct3 == 3'b101 ? (f7_alt ? OP_SRA : OP_SRL) :
                  bus.funct3 == 3'b110 ? OP_OR : OP_AND;
  assign shamt = s1_b[SH-1:0];
  assign sum = s1_a + s1_b;
  assign diff = s1_a - s1_b;
  // Kept as its own net so the arithmetic shift is not turned logical by unsigned neighbours.
  assign sra = $signed(s1_a) >>> shamt;
  assign lt_s = $signed(s1_a) < $signed(s1_b);
  assign lt_u = s1_a < s1_b;
  assign res = s1_illegal ? '0 :
               s1_op == OP_ADD  ? sum :
               s1_op == OP_SUB  ? diff :
               s1_op == OP_XOR  ? s1_a ^ s1_b :
               s1_op == OP_OR   ? s1_a | s1_b :
               s1_op == OP_AND  ? s1_a & s1_b :
               s1_op == OP_SLL  ? s1_a << shamt :
               s1_op == OP_SRL  ? s1_a >> shamt :
               s1_op == OP_SRA  ? sra :
               s1_op == OP_SLT  ? {{(WIDTH-1){1'b0}}, lt_s} :
               s1_op == OP_SLTU ? {{(WIDTH-1){1'b0}}, lt_u} : '0;
`ifdef ALU_FLAGS_EN
  logic f_c;
  logic f_v;
  logic fz_q;
  logic fn_q;
  logic fc_q;
  logic fv_q;
  // Carry of ADD shows as unsigned wrap; carry of SUB is the no-borrow condition a >= b.
  assign f_c = s1_op == OP_ADD ? sum < s1_a :
               s1_op == OP_SUB ? !lt_u : 1'b0;
  assign f_v = s1_op == OP_ADD ? (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]) :
               s1_op == OP_SUB ? (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]) : 1'b0;
  assign bus.flag_z = fz_q;
  assign bus.flag_n = fn_q;
  assign bus.flag_c = fc_q;
  assign bus.flag_v = fv_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_op <= '0;
      s1_illegal <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_tag <= '0;
      result_q <= '0;
      tag_q <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fc_q <= 1'b0;
      fv_q <= 1'b0;
`endif
    end else begin
      if (s1_load) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_op <= dec_op;
        s1_illegal <= dec_illegal;
        s1_a <= bus.a;
        s1_b <= bus.b;
        s1_tag <= bus.in_tag;
      end
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        result_q <= res;
        tag_q <= s1_tag;
        illegal_q <= s1_illegal;
`ifdef ALU_FLAGS_EN
        fz_q <= !s1_illegal && res == '0;
        fn_q <= !s1_illegal && res[WIDTH-1];
        fc_q <= !s1_illegal && f_c;
        fv_q <= !s1_illegal && f_v;
`endif
      end
    end
  end
endmodule
